// File: rtl/adder_tree_accum_drain.sv
// rtl/adder_tree_accum_drain.sv - accumulate NGROUP adder-tree results into group sums drained through a small FIFO
module adder_tree_accum_drain #(
    parameter int IN_W   = 16,
    parameter int ACC_W  = 24,
    parameter int NGROUP = 4,
    parameter int DEPTH  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [IN_W-1:0]  i_r,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_data,
    output logic             o_partial
);

    localparam int CNT_W = (NGROUP > 1) ? $clog2(NGROUP) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NGROUP - 1);

    if (ACC_W < IN_W + $clog2(NGROUP)) begin : g_bad_acc_w
        $error("ACC_W too narrow for IN_W and NGROUP");
    end
    if (NGROUP < 1) begin : g_bad_ngroup
        $error("NGROUP must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    typedef enum logic {
        S_EMPTY,
        S_FILL
    } state_t;

    state_t state, state_n;

    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic signed [IN_W-1:0]  r_s;
    logic signed [ACC_W-1:0] r_ext;
    logic [ACC_W-1:0]        sum;

    logic             accept;
    logic             flush;
    logic             push;
    logic             pop;
    logic             push_partial;
    logic [ACC_W-1:0] push_data;

    logic [ACC_W:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full;
    logic             fifo_empty;

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    // Ready depends only on local occupancy, never on o_ready.
    assign i_ready = !fifo_full && !RST;
    assign o_valid = !fifo_empty && !RST;

    assign o_data    = o_valid ? mem[rd_ptr][ACC_W-1:0] : '0;
    assign o_partial = o_valid ? mem[rd_ptr][ACC_W] : 1'b0;

    assign accept = i_valid && i_ready;
    assign flush  = i_flush && i_ready;
    assign pop    = o_valid && o_ready;

    assign r_s   = i_r;
    assign r_ext = ACC_W'(r_s);
    assign sum   = acc + r_ext;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_EMPTY;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        push         = 1'b0;
        push_partial = 1'b0;
        push_data    = sum;

        if (accept) begin
            // An input arriving with a flush is folded in before the group closes.
            if (cnt == LAST_CNT || flush) begin
                push         = 1'b1;
                push_partial = (cnt != LAST_CNT);
                push_data    = sum;
                acc_n        = '0;
                cnt_n        = '0;
                state_n      = S_EMPTY;
            end else begin
                acc_n   = sum;
                cnt_n   = cnt + CNT_W'(1);
                state_n = S_FILL;
            end
        end else if (flush) begin
            case (state)
                S_FILL: begin
                    push         = 1'b1;
                    push_partial = 1'b1;
                    push_data    = acc;
                    acc_n        = '0;
                    cnt_n        = '0;
                    state_n      = S_EMPTY;
                end
                default: begin
                    state_n = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {push_partial, push_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_accum_drain.sv
// tb/tb_adder_tree_accum_drain.sv - directed self-checking bench for adder_tree_accum_drain
module tb_adder_tree_accum_drain;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_r;
    logic        i_flush;
    logic        o_valid;
    logic        o_ready;
    logic [23:0] o_data;
    logic        o_partial;

    int checks   = 0;
    int failures = 0;

    logic [24:0] got [$];

    adder_tree_accum_drain #(
        .IN_W  (16),
        .ACC_W (24),
        .NGROUP(4),
        .DEPTH (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_r      (i_r),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_partial(o_partial)
    );

    always #5 CLK = ~CLK;

    // Words leave the FIFO on the next rising edge when valid and ready are both high here.
    always @(negedge CLK) begin
        if (o_valid && o_ready) begin
            got.push_back({o_partial, o_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic v, input logic [15:0] r, input logic fl);
        int n;
        i_valid = v;
        i_r     = r;
        i_flush = fl;
        n = 0;
        @(negedge CLK);
        while (!i_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!i_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic check_got(input string tag, input int idx, input logic [24:0] exp);
        if (idx < got.size()) begin
            check(tag, 32'(got[idx]), 32'(exp));
        end else begin
            check(tag, 32'h0BAD_0000, 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        RST     = 1'b1;
        i_valid = 1'b0;
        i_r     = '0;
        i_flush = 1'b0;
        o_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_partial", 32'(o_partial), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_i_ready", 32'(i_ready), 32'd1);
        @(posedge CLK);
        #1;

        // Basic group: 5 - 3 + 100 + 7 = 109, one cycle latency
        o_ready = 1'b1;
        send(1'b1, 16'd5, 1'b0);
        send(1'b1, 16'hFFFD, 1'b0);
        send(1'b1, 16'd100, 1'b0);
        send(1'b1, 16'd7, 1'b0);
        check("basic_latency_valid", 32'(o_valid), 32'd1);
        check("basic_latency_data", 32'(o_data), 32'd109);
        idle(1);
        check("basic_valid_drop", 32'(o_valid), 32'd0);
        idle(2);
        check("basic_count", 32'(got.size()), 32'd1);
        check_got("basic_word", 0, {1'b0, 24'd109});
        got.delete();

        // Sign extension: 4 x -32768 = -131072
        for (int k = 0; k < 4; k++) send(1'b1, 16'h8000, 1'b0);
        idle(3);
        check("sext_count", 32'(got.size()), 32'd1);
        check_got("sext_word", 0, {1'b0, 24'hFE0000});
        got.delete();

        // Flush: partial 30, then full group 4, then flush in EMPTY emits nothing
        send(1'b1, 16'd10, 1'b0);
        send(1'b1, 16'd20, 1'b0);
        send(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 4; k++) send(1'b1, 16'd1, 1'b0);
        send(1'b0, 16'd0, 1'b1);
        idle(4);
        check("flush_count", 32'(got.size()), 32'd2);
        check_got("flush_partial_word", 0, {1'b1, 24'd30});
        check_got("flush_full_word", 1, {1'b0, 24'd4});
        got.delete();

        // Flush with accept mid-group: 3 + 4 = 7, partial
        send(1'b1, 16'd3, 1'b0);
        send(1'b1, 16'd4, 1'b1);
        idle(3);
        check("flush_acc_count", 32'(got.size()), 32'd1);
        check_got("flush_acc_word", 0, {1'b1, 24'd7});
        got.delete();

        // Backpressure: 4 groups fill the FIFO, 5th group held off until a pop
        o_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(1'b1, 16'd1, 1'b0);
        check("bp_full_i_ready", 32'(i_ready), 32'd0);
        check("bp_head_valid", 32'(o_valid), 32'd1);
        check("bp_head_data", 32'(o_data), 32'd4);
        i_valid = 1'b1;
        i_r     = 16'd1;
        idle(3);
        check("bp_held_i_ready", 32'(i_ready), 32'd0);
        check("bp_head_stable", 32'(o_data), 32'd4);
        check("bp_no_output", 32'(got.size()), 32'd0);
        o_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(1'b1, 16'd1, 1'b0);
        idle(10);
        check("bp_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5; k++) check_got("bp_word", k, {1'b0, 24'd4});
        got.delete();

        // Simultaneous push and pop with one entry held
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(1'b1, 16'd1, 1'b0);
        for (int k = 0; k < 3; k++) send(1'b1, 16'd2, 1'b0);
        check("pp_one_entry", 32'(o_data), 32'd4);
        o_ready = 1'b1;
        send(1'b1, 16'd2, 1'b0);
        check("pp_valid", 32'(o_valid), 32'd1);
        check("pp_new_head", 32'(o_data), 32'd8);
        idle(1);
        check("pp_drained", 32'(o_valid), 32'd0);
        idle(2);
        check("pp_count", 32'(got.size()), 32'd2);
        check_got("pp_word0", 0, {1'b0, 24'd4});
        check_got("pp_word1", 1, {1'b0, 24'd8});
        got.delete();

        // Reset mid-operation discards queued words and partial sum
        o_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(1'b1, 16'd1, 1'b0);
        send(1'b1, 16'd7, 1'b0);
        send(1'b1, 16'd7, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_o_valid", 32'(o_valid), 32'd0);
        check("mid_rst_i_ready", 32'(i_ready), 32'd0);
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        o_ready = 1'b1;
        check("after_rst_o_valid", 32'(o_valid), 32'd0);
        send(1'b1, 16'd1, 1'b0);
        send(1'b1, 16'd2, 1'b0);
        send(1'b1, 16'd3, 1'b0);
        send(1'b1, 16'd4, 1'b0);
        idle(5);
        check("after_rst_count", 32'(got.size()), 32'd1);
        check_got("after_rst_word", 0, {1'b0, 24'd10});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
